pci_avm_burst_splitter: RTL and testbench

//  Sits between the ao486 Avalon memory-window master and the PCI bridge Avalon slave; the bridge handles single beats only.

---
 rtl/pci_avm_burst_splitter.sv | 259 +++++++++++++++++++++++++
 tb/tb_pci_avm_burst_splitter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pci_avm_burst_splitter.sv
// pci_avm_burst_splitter
//
// Bridges the ao486 Avalon memory-window master (bursting) to the PCI bridge
// Avalon slave, which only understands single beats.
//   - Write bursts are split into single-word writes with incrementing word
//     addresses and posted into a small FIFO. The FIFO is drained towards the
//     bridge in the background.
//   - Read bursts are serialised: one single-beat read at a time, and only
//     after every posted write has left the FIFO. This keeps program order
//     across the PCI bus.
//
// Ports
//   clk, rst           system clock, synchronous active-high reset
//   s_*                Avalon slave side (from the CPU memory window)
//     s_address        burst start word address
//     s_writedata      write beat data
//     s_byteenable     write beat byte enables
//     s_burstcount     beats in burst (0 behaves as 1)
//     s_write/s_read   write beat request / read burst command
//     s_waitrequest    combinational stall back to the master
//     s_readdatavalid  one pulse per returned read beat
//     s_readdata       read beat data (pass-through of m_readdata)
//   m_*                Avalon master side (to the PCI bridge), single beats
//     m_address, m_writedata, m_byteenable, m_write, m_read  registered
//     m_waitrequest, m_readdatavalid, m_readdata             from bridge
//   busy               high while a burst is in flight or writes are posted
module pci_avm_burst_splitter #(
  parameter int ADDR_W     = 22,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_address,
  input  logic [31:0]       s_writedata,
  input  logic [3:0]        s_byteenable,
  input  logic [3:0]        s_burstcount,
  input  logic              s_write,
  input  logic              s_read,
  output logic              s_waitrequest,
  output logic              s_readdatavalid,
  output logic [31:0]       s_readdata,
  output logic [ADDR_W-1:0] m_address,
  output logic [31:0]       m_writedata,
  output logic [3:0]        m_byteenable,
  output logic              m_write,
  output logic              m_read,
  input  logic              m_waitrequest,
  input  logic              m_readdatavalid,
  input  logic [31:0]       m_readdata,
  output logic              busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_BURST = 3'd1,
    RD_DRAIN = 3'd2,
    RD_ISSUE = 3'd3,
    RD_WAIT  = 3'd4
  } state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] base_reg;
  logic [3:0]        cnt_reg;     // beats in current burst (1..15)
  logic [3:0]        beat_reg;    // next beat index within the burst

  // Posted-write FIFO storage; plain arrays so they map to RAM.
  logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
  logic [31:0]       data_mem [FIFO_DEPTH];
  logic [3:0]        be_mem   [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W:0]    count_reg;
  logic [PTR_W:0]    count_next;

  // Registered bridge-side outputs.
  logic              m_write_reg;
  logic              m_read_reg;
  logic [ADDR_W-1:0] m_address_reg;
  logic [31:0]       m_writedata_reg;
  logic [3:0]        m_byteenable_reg;

  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              push;
  logic              load;
  logic              rd_state;
  logic              drain_ok;
  logic              wr_accept;
  logic              rd_accept;
  logic [3:0]        burst_len;
  logic [3:0]        beat_inc;
  logic [ADDR_W-1:0] push_addr;

  assign fifo_full  = (count_reg == DEPTH_C);
  assign fifo_empty = (count_reg == '0);

  // The head entry stays in the FIFO until the bridge takes it, so a full
  // FIFO really means FIFO_DEPTH beats waiting on the bridge. A pop in the
  // same cycle frees the slot the incoming beat needs.
  assign pop = m_write_reg && !m_waitrequest;

  assign rd_state = (state_reg == RD_DRAIN) || (state_reg == RD_ISSUE) ||
                    (state_reg == RD_WAIT);
  assign drain_ok = (state_reg == IDLE) || (state_reg == WR_BURST) ||
                    (state_reg == RD_DRAIN);

  assign s_waitrequest = rst || rd_state || (fifo_full && !pop);

  assign wr_accept = s_write && !s_waitrequest &&
                     ((state_reg == IDLE) || (state_reg == WR_BURST));
  // A simultaneous write always wins over a read command.
  assign rd_accept = s_read && !s_write && !s_waitrequest && (state_reg == IDLE);

  assign burst_len = (s_burstcount == 4'd0) ? 4'd1 : s_burstcount;
  assign beat_inc  = beat_reg + 4'd1;

  // Beat 0 of a burst takes the live address; later beats are base+n and
  // wrap modulo 2^ADDR_W through natural truncation.
  assign push_addr = (state_reg == IDLE) ? s_address
                                         : base_reg + ADDR_W'(beat_reg);

  assign push = wr_accept;

  // Present the next head only when nothing is currently on the bus. This
  // gives one idle cycle between consecutive writes, which keeps the head
  // read a plain registered RAM read.
  assign load = drain_ok && !m_write_reg && !fifo_empty;

  assign count_next = count_reg + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

  // FIFO storage writes. No reset: contents are qualified by count_reg.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_reg] <= push_addr;
      data_mem[wr_ptr_reg] <= s_writedata;
      be_mem[wr_ptr_reg]   <= s_byteenable;
    end
  end

  // Control FSM, FIFO pointers and registered bridge outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      base_reg         <= '0;
      cnt_reg          <= '0;
      beat_reg         <= '0;
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      m_write_reg      <= 1'b0;
      m_read_reg       <= 1'b0;
      m_address_reg    <= '0;
      m_writedata_reg  <= '0;
      m_byteenable_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_next;

      // Write drain. load and pop are mutually exclusive (load needs the
      // bus idle), and load never coincides with a push into the head slot
      // because that slot is only reused when the FIFO is full and popping.
      if (pop) begin
        m_write_reg <= 1'b0;
      end else if (load) begin
        m_write_reg      <= 1'b1;
        m_address_reg    <= addr_mem[rd_ptr_reg];
        m_writedata_reg  <= data_mem[rd_ptr_reg];
        m_byteenable_reg <= be_mem[rd_ptr_reg];
      end

      case (state_reg)
        IDLE: begin
          if (wr_accept) begin
            base_reg <= s_address;
            cnt_reg  <= burst_len;
            beat_reg <= 4'd1;
            if (burst_len != 4'd1) begin
              state_reg <= WR_BURST;
            end
          end else if (rd_accept) begin
            base_reg  <= s_address;
            cnt_reg   <= burst_len;
            beat_reg  <= 4'd0;
            state_reg <= RD_DRAIN;
          end
        end

        WR_BURST: begin
          if (wr_accept) begin
            if (beat_inc == cnt_reg) begin
              state_reg <= IDLE;
            end else begin
              beat_reg <= beat_inc;
            end
          end
        end

        RD_DRAIN: begin
          // Empty FIFO implies load is idle, so m_read and m_write can never
          // be raised together.
          if (fifo_empty && !m_write_reg) begin
            state_reg        <= RD_ISSUE;
            m_read_reg       <= 1'b1;
            m_address_reg    <= base_reg + ADDR_W'(beat_reg);
            m_byteenable_reg <= 4'hF;
          end
        end

        RD_ISSUE: begin
          if (!m_waitrequest) begin
            m_read_reg <= 1'b0;
            state_reg  <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          if (m_readdatavalid) begin
            if (beat_inc == cnt_reg) begin
              state_reg <= IDLE;
            end else begin
              beat_reg         <= beat_inc;
              state_reg        <= RD_ISSUE;
              m_read_reg       <= 1'b1;
              m_address_reg    <= base_reg + ADDR_W'(beat_inc);
              m_byteenable_reg <= 4'hF;
            end
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign m_write      = m_write_reg;
  assign m_read       = m_read_reg;
  assign m_address    = m_address_reg;
  assign m_writedata  = m_writedata_reg;
  assign m_byteenable = m_byteenable_reg;

  // Read data is passed straight through; validity is gated by state so a
  // stray bridge pulse (e.g. after a reset) never reaches the master.
  assign s_readdata      = m_readdata;
  assign s_readdatavalid = !rst && (state_reg == RD_WAIT) && m_readdatavalid;

  assign busy = (state_reg != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_pci_avm_burst_splitter.sv
module tb_pci_avm_burst_splitter;

  localparam int ADDR_W     = 22;
  localparam int FIFO_DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] s_address;
  logic [31:0]       s_writedata;
  logic [3:0]        s_byteenable;
  logic [3:0]        s_burstcount;
  logic              s_write;
  logic              s_read;
  logic              s_waitrequest;
  logic              s_readdatavalid;
  logic [31:0]       s_readdata;
  logic [ADDR_W-1:0] m_address;
  logic [31:0]       m_writedata;
  logic [3:0]        m_byteenable;
  logic              m_write;
  logic              m_read;
  logic              m_waitrequest;
  logic              m_readdatavalid;
  logic [31:0]       m_readdata;
  logic              busy;

  always #5 clk = ~clk;

  pci_avm_burst_splitter #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_address(s_address), .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_burstcount(s_burstcount), .s_write(s_write), .s_read(s_read),
    .s_waitrequest(s_waitrequest), .s_readdatavalid(s_readdatavalid),
    .s_readdata(s_readdata),
    .m_address(m_address), .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_write(m_write), .m_read(m_read), .m_waitrequest(m_waitrequest),
    .m_readdatavalid(m_readdatavalid), .m_readdata(m_readdata),
    .busy(busy)
  );

  // Expected bridge-side operations in program order.
  typedef struct {
    bit                is_rd;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [3:0]        be;
  } op_t;

  op_t         exp_q[$];
  logic [31:0] rdata_q[$];
  op_t         mon_e;

  int checks = 0;
  int errors = 0;

  // Bridge model controls: 0 random stall, 1 always stall, 2 never stall.
  int stall_mode = 2;
  bit rd_pending = 0;
  bit rd_hold    = 0;
  bit drop_rdv   = 0;
  int rd_lat     = 0;

  int srdv_cnt  = 0;
  int mrd_cnt   = 0;
  int wr_beats  = 0;
  int t3_base   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Monitor / scoreboard: samples on the falling edge, when all inputs and
  // registered outputs are stable for the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_waitrequest", s_waitrequest, 1);
      check("rst_readdatavalid", s_readdatavalid, 0);
    end else begin
      check("rd_wr_exclusive", m_read && m_write, 0);
      if (m_write && !m_waitrequest) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_m_write");
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_is_write", mon_e.is_rd, 0);
          check("wr_addr", m_address, mon_e.addr);
          check("wr_data", m_writedata, mon_e.data);
          check("wr_be", m_byteenable, mon_e.be);
          $display("bridge write addr=%06h data=%08h be=%h", m_address, m_writedata, m_byteenable);
        end
      end
      if (m_read && !m_waitrequest) begin
        mrd_cnt++;
        rd_pending = 1;
        if (exp_q.size() == 0) begin
          fail_now("unexpected_m_read");
        end else begin
          mon_e = exp_q.pop_front();
          check("rd_is_read", mon_e.is_rd, 1);
          check("rd_addr", m_address, mon_e.addr);
          check("rd_be", m_byteenable, 4'hF);
          $display("bridge read  addr=%06h", m_address);
        end
      end
      if (s_readdatavalid) begin
        srdv_cnt++;
        if (rdata_q.size() == 0) begin
          fail_now("unexpected_s_readdatavalid");
        end else begin
          check("s_readdata", s_readdata, rdata_q.pop_front());
          $display("read return data=%08h", s_readdata);
        end
      end
    end
  end

  // Bridge model: drives stall and returns one read beat per accepted read.
  always @(posedge clk) begin
    #2;
    case (stall_mode)
      1:       m_waitrequest = 1'b1;
      2:       m_waitrequest = 1'b0;
      default: m_waitrequest = ($urandom_range(0, 2) == 0);
    endcase
    m_readdatavalid = 1'b0;
    if (rd_pending && !rd_hold) begin
      if (rd_lat == 0) begin
        m_readdatavalid = 1'b1;
        m_readdata      = $urandom;
        if (drop_rdv) drop_rdv = 0;
        else rdata_q.push_back(m_readdata);
        rd_pending = 0;
        rd_lat     = $urandom_range(0, 3);
      end else begin
        rd_lat--;
      end
    end
  end

  task automatic wait_accept(input string name);
    int t = 0;
    @(negedge clk);
    while (s_waitrequest && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) fail_now(name);
  endtask

  // be0 == 0 selects random byte enables per beat.
  task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [3:0] bc,
                          input logic [31:0] d0, input logic [3:0] be0);
    int  n;
    op_t o;
    n = (bc == 0) ? 1 : int'(bc);
    for (int k = 0; k < n; k++) begin
      s_write      = 1'b1;
      s_address    = addr;
      s_burstcount = bc;
      s_writedata  = d0 + 32'h01010101 * k;
      s_byteenable = (be0 != 0) ? be0 : 4'($urandom);
      wait_accept("wr_beat_timeout");
      o.is_rd = 0;
      o.addr  = addr + ADDR_W'(k);
      o.data  = s_writedata;
      o.be    = s_byteenable;
      exp_q.push_back(o);
      wr_beats++;
      @(posedge clk); #1;
    end
    s_write = 1'b0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] addr, input logic [3:0] bc);
    int  n;
    op_t o;
    n = (bc == 0) ? 1 : int'(bc);
    s_read       = 1'b1;
    s_address    = addr;
    s_burstcount = bc;
    wait_accept("rd_cmd_timeout");
    for (int k = 0; k < n; k++) begin
      o.is_rd = 1;
      o.addr  = addr + ADDR_W'(k);
      o.data  = '0;
      o.be    = 4'hF;
      exp_q.push_back(o);
    end
    @(posedge clk); #1;
    s_read = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || rdata_q.size() != 0 || rd_pending) && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 3000) fail_now(name);
    repeat (2) @(posedge clk);
    #1;
    check({name, "_busy"}, busy, 0);
  endtask

  task automatic reset_dut(input bit keep_pending);
    rst     = 1'b1;
    s_write = 1'b0;
    s_read  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_q.delete();
    rdata_q.delete();
    if (!keep_pending) rd_pending = 0;
    rst = 1'b0;
    check("post_rst_m_write", m_write, 0);
    check("post_rst_m_read", m_read, 0);
    check("post_rst_m_address", m_address, 0);
    check("post_rst_busy", busy, 0);
  endtask

  int n0;
  int r0;
  int tw;
  logic [ADDR_W-1:0] ra;

  initial begin
    rst             = 1'b1;
    s_address       = '0;
    s_writedata     = '0;
    s_byteenable    = '0;
    s_burstcount    = '0;
    s_write         = 1'b0;
    s_read          = 1'b0;
    m_waitrequest   = 1'b0;
    m_readdatavalid = 1'b0;
    m_readdata      = '0;
    @(posedge clk); #1;
    reset_dut(0);

    // T1: single write, bridge stalls 3 cycles.
    stall_mode = 1;
    do_write(22'h000100, 4'd1, 32'hDEADBEEF, 4'hF);
    @(posedge clk); #1;
    check("t1_m_write", m_write, 1);
    check("t1_m_address", m_address, 22'h000100);
    check("t1_m_writedata", m_writedata, 32'hDEADBEEF);
    repeat (2) @(posedge clk);
    #1;
    check("t1_held", m_write, 1);
    @(negedge clk);
    stall_mode = 2;
    wait_idle("t1_drain");

    // T2: burst across the top of the address space.
    stall_mode = 0;
    do_write(22'h3FFFFE, 4'd4, 32'h11223344, 4'h0);
    wait_idle("t2_drain");

    // T3: fill the FIFO with the bridge stalled.
    stall_mode = 1;
    t3_base = wr_beats;
    fork
      begin
        repeat (20) @(negedge clk);
        check("t3_beats_before_full", wr_beats - t3_base, FIFO_DEPTH);
        check("t3_waitrequest", s_waitrequest, 1);
        stall_mode = 0;
      end
    join_none
    do_write(22'h001000, 4'd12, 32'hA0000000, 4'h0);
    wait_idle("t3_drain");

    // T4: read after posted writes.
    stall_mode = 0;
    do_write(22'h000200, 4'd3, 32'h55AA0000, 4'h0);
    do_read(22'h000020, 4'd2);
    wait_idle("t4_drain");

    // T5: burstcount 0 read behaves as a single beat.
    n0 = srdv_cnt;
    r0 = mrd_cnt;
    do_read(22'h000040, 4'd0);
    wait_idle("t5_drain");
    check("t5_m_read_count", mrd_cnt - r0, 1);
    check("t5_rdv_count", srdv_cnt - n0, 1);

    // T6: reset in RD_WAIT, then a late bridge readdatavalid.
    stall_mode = 2;
    rd_hold    = 1;
    do_read(22'h000080, 4'd1);
    tw = 0;
    while (!rd_pending && tw < 100) begin
      @(posedge clk); #1;
      tw++;
    end
    if (tw >= 100) fail_now("t6_read_issue_timeout");
    repeat (2) @(posedge clk);
    #1;
    reset_dut(1);
    drop_rdv = 1;
    rd_hold  = 0;
    n0 = srdv_cnt;
    repeat (8) @(posedge clk);
    #1;
    check("t6_late_rdv", srdv_cnt - n0, 0);

    // Reset with posted writes waiting in the FIFO.
    stall_mode = 1;
    do_write(22'h000300, 4'd2, 32'hCAFE0000, 4'h0);
    repeat (3) @(posedge clk);
    #1;
    check("t6b_busy_before", busy, 1);
    reset_dut(0);

    // Randomised traffic.
    stall_mode = 0;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) ra = 22'h3FFFF8 + ADDR_W'($urandom_range(0, 7));
      else ra = ADDR_W'($urandom);
      if ($urandom_range(0, 2) == 0) do_read(ra, 4'($urandom_range(0, 15)));
      else do_write(ra, 4'($urandom_range(0, 15)), $urandom, 4'h0);
    end
    wait_idle("random_drain");
    check("final_exp_q_empty", exp_q.size(), 0);
    check("final_rdata_q_empty", rdata_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
